// File: rtl/vec_store_unit.sv
// Vector store unit: captures one vector register and a base address on a
// store instruction, then writes the elements to memory one beat at a time
// at unit or constant (possibly negative or zero) stride.
module vec_store_unit #(
    parameter int XLEN     = 32,
    parameter int VLEN     = 512,
    parameter int SEW      = 32,
    parameter int VLMAX    = VLEN / SEW,
    parameter int MAX_VLEN = 4096
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic                stride_sel,
    input  logic                st_inst,
    input  logic [MAX_VLEN-1:0] vs3_data,
    output logic [XLEN-1:0]     lsu2mem_addr,
    output logic [SEW-1:0]      lsu2mem_data,
    output logic                lsu2mem_wen,
    input  logic                mem2lsu_ready,
    output logic                st_busy,
    output logic                is_stored
);

    localparam int IDX_W = (VLMAX > 1) ? $clog2(VLMAX) : 1;
    localparam logic [XLEN-1:0]  UNIT_STRIDE = XLEN'(SEW / 8);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(VLMAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [SEW-1:0]          elem_buf [VLMAX];
    logic [XLEN-1:0]         addr_reg;
    logic signed [XLEN-1:0]  stride_reg;
    logic [IDX_W-1:0]        idx;
    logic                    accept;
    logic                    beat_done;

    assign accept    = (state == IDLE) && st_inst;
    assign beat_done = (state == STORE) && mem2lsu_ready;

    // Register-file bits above the stored vector are never consumed.
    generate
        if (MAX_VLEN > VLMAX * SEW) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^vs3_data[MAX_VLEN-1:VLMAX*SEW];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, walk VLMAX beats, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (st_inst) state_nxt = STORE;
            STORE:   if (mem2lsu_ready && (idx == LAST_IDX)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, advance address/index per accepted beat.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_reg   <= '0;
            stride_reg <= '0;
            idx        <= '0;
            for (int i = 0; i < VLMAX; i++) begin
                elem_buf[i] <= '0;
            end
        end else if (accept) begin
            addr_reg   <= rs1_data;
            stride_reg <= stride_sel ? $signed(UNIT_STRIDE) : $signed(rs2_data);
            idx        <= '0;
            for (int i = 0; i < VLMAX; i++) begin
                elem_buf[i] <= vs3_data[i*SEW +: SEW];
            end
        end else if (beat_done) begin
            // Two's-complement add gives modulo-2^XLEN wrap for negative strides.
            addr_reg <= addr_reg + $unsigned(stride_reg);
            idx      <= idx + IDX_W'(1);
        end
    end

    // Outputs decoded from state so reset drops them immediately.
    always_comb begin
        lsu2mem_wen  = 1'b0;
        lsu2mem_addr = '0;
        lsu2mem_data = '0;
        st_busy      = 1'b0;
        is_stored    = 1'b0;
        case (state)
            STORE: begin
                lsu2mem_wen  = 1'b1;
                lsu2mem_addr = addr_reg;
                lsu2mem_data = elem_buf[idx];
                st_busy      = 1'b1;
            end
            DONE: begin
                st_busy   = 1'b1;
                is_stored = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vec_store_unit.sv
// Bench for vec_store_unit: table of store cases plus hand sequences for
// busy guard and mid-store reset; beats checked against a scoreboard queue.
module tb_vec_store_unit;

    localparam int XLEN     = 32;
    localparam int SEW      = 32;
    localparam int VLMAX    = 16;
    localparam int MAX_VLEN = 4096;

    logic                clk;
    logic                n_rst;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic                stride_sel;
    logic                st_inst;
    logic [MAX_VLEN-1:0] vs3_data;
    logic [XLEN-1:0]     lsu2mem_addr;
    logic [SEW-1:0]      lsu2mem_data;
    logic                lsu2mem_wen;
    logic                mem2lsu_ready;
    logic                st_busy;
    logic                is_stored;

    vec_store_unit #(
        .XLEN(XLEN), .VLEN(512), .SEW(SEW), .VLMAX(VLMAX), .MAX_VLEN(MAX_VLEN)
    ) dut (
        .clk(clk), .n_rst(n_rst), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stride_sel(stride_sel), .st_inst(st_inst), .vs3_data(vs3_data),
        .lsu2mem_addr(lsu2mem_addr), .lsu2mem_data(lsu2mem_data),
        .lsu2mem_wen(lsu2mem_wen), .mem2lsu_ready(mem2lsu_ready),
        .st_busy(st_busy), .is_stored(is_stored)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        string       name;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        sel;
        logic [31:0] dbase;
        int          stall_start;
        int          stall_len;
        int          exp_lat;
        logic [31:0] exp_last;
    } case_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    logic [31:0] last_addr = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Beat monitor: every presented beat must match the scoreboard head; it is
    // popped only when accepted, so a stalled beat is re-checked each cycle.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (lsu2mem_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h expected no beat",
                             lsu2mem_addr, lsu2mem_data);
                end else begin
                    chk("beat_addr", 64'(lsu2mem_addr), 64'(exp_q[0].addr));
                    chk("beat_data", 64'(lsu2mem_data), 64'(exp_q[0].data));
                    if (mem2lsu_ready === 1'b1) begin
                        last_addr = lsu2mem_addr;
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end else begin
                chk("idle_addr", 64'(lsu2mem_addr), 64'd0);
                chk("idle_data", 64'(lsu2mem_data), 64'd0);
            end
        end
    end

    // Drive one accept cycle and push the expected beats; returns at cycle 1 (+2).
    task automatic start_store(input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic sel, input logic [31:0] dbase);
        logic [31:0] stride;
        stride = sel ? 32'd4 : rs2;
        rs1_data   = rs1;
        rs2_data   = rs2;
        stride_sel = sel;
        for (int i = 0; i < VLMAX; i++) begin
            vs3_data[i*SEW +: SEW] = dbase + 32'(i);
            exp_q.push_back('{addr: rs1 + 32'(i) * stride, data: dbase + 32'(i)});
        end
        st_inst = 1'b1;
        @(posedge clk); #2;
        st_inst = 1'b0;
        // Inputs are don't-care after accept; scramble them.
        rs1_data = $urandom;
        rs2_data = $urandom;
        stride_sel = 1'($urandom);
        for (int i = 0; i < MAX_VLEN / 32; i++) vs3_data[i*32 +: 32] = $urandom;
    endtask

    // Run until is_stored, applying a ready stall window and optional busy-guard pulse.
    task automatic finish_store(input string name, input int stall_start, input int stall_len,
                                input bit guard, input int exp_lat, input logic [31:0] exp_last);
        int cyc;
        bit done;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 200) begin
            cyc++;
            mem2lsu_ready = !(stall_len > 0 && cyc >= stall_start && cyc < stall_start + stall_len);
            if (guard && cyc == 4) begin
                st_inst  = 1'b1;
                rs1_data = 32'h9000;
            end
            if (guard && cyc == 5) st_inst = 1'b0;
            @(negedge clk);
            if (is_stored === 1'b1) done = 1;
            else begin
                @(posedge clk); #2;
            end
        end
        if (!done) $display("FAIL %s_timeout: got no is_stored expected pulse", name);
        chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({name, "_busy_done"}, 64'(st_busy), 64'd1);
        chk({name, "_last_addr"}, 64'(last_addr), 64'(exp_last));
        chk({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #2;
        mem2lsu_ready = 1'b1;
        @(negedge clk);
        chk({name, "_stored_pulse"}, 64'(is_stored), 64'd0);
        chk({name, "_busy_idle"}, 64'(st_busy), 64'd0);
        @(posedge clk); #2;
    endtask

    case_t cases[6];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        cases[0] = '{"unit",     32'h100,      32'h0,        1'b1, 32'hA0,  0, 0, 17, 32'h13C};
        cases[1] = '{"const",    32'h2000,     32'h10,       1'b0, 32'hB00, 0, 0, 17, 32'h20F0};
        cases[2] = '{"stall",    32'h100,      32'h0,        1'b1, 32'hC0,  6, 3, 20, 32'h13C};
        cases[3] = '{"wrap",     32'hFFFF_FFF8, 32'h0,       1'b1, 32'hD0,  0, 0, 17, 32'h34};
        cases[4] = '{"negative", 32'h40,       32'hFFFF_FFFC, 1'b0, 32'hE0, 0, 0, 17, 32'h4};
        cases[5] = '{"zero",     32'h500,      32'h0,        1'b0, 32'hF0,  0, 0, 17, 32'h500};

        n_rst = 1'b0;
        rs1_data = '0; rs2_data = '0; stride_sel = 1'b0; st_inst = 1'b0;
        vs3_data = '0; mem2lsu_ready = 1'b1;
        #3;
        chk("rst_wen", 64'(lsu2mem_wen), 64'd0);
        chk("rst_addr", 64'(lsu2mem_addr), 64'd0);
        chk("rst_data", 64'(lsu2mem_data), 64'd0);
        chk("rst_busy", 64'(st_busy), 64'd0);
        chk("rst_stored", 64'(is_stored), 64'd0);
        @(posedge clk); #2;
        n_rst = 1'b1;
        @(posedge clk); #2;

        for (int k = 0; k < 6; k++) begin
            start_store(cases[k].rs1, cases[k].rs2, cases[k].sel, cases[k].dbase);
            finish_store(cases[k].name, cases[k].stall_start, cases[k].stall_len, 1'b0,
                         cases[k].exp_lat, cases[k].exp_last);
        end

        // Busy guard: a second st_inst during STORE must be ignored.
        start_store(32'h300, 32'h0, 1'b1, 32'h11);
        finish_store("guard", 0, 0, 1'b1, 17, 32'h33C);

        // Reset mid-store after beat 7 is accepted.
        beats_seen = 0;
        start_store(32'h600, 32'h0, 1'b1, 32'h55);
        n = 0;
        while (beats_seen < 8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_reached", 64'(beats_seen), 64'd8);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_wen", 64'(lsu2mem_wen), 64'd0);
        chk("rst_mid_addr", 64'(lsu2mem_addr), 64'd0);
        chk("rst_mid_data", 64'(lsu2mem_data), 64'd0);
        chk("rst_mid_busy", 64'(st_busy), 64'd0);
        chk("rst_mid_stored", 64'(is_stored), 64'd0);
        exp_q.delete();
        @(posedge clk); #2;
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_rel_wen", 64'(lsu2mem_wen), 64'd0);
        chk("rst_rel_busy", 64'(st_busy), 64'd0);
        @(posedge clk); #2;
        start_store(32'h700, 32'h0, 1'b1, 32'h77);
        finish_store("post_rst", 0, 0, 1'b0, 17, 32'h73C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
